pwm_duty_capture: RTL
=====================

PWM_DUTY_CAPTURE -- requirements
Module: pwm_duty_capture

Interface
REQ-001 SHALL have parameter MIN_PERIOD, default 16, minimum accepted period in clk cycles.
REQ-002 SHALL have parameter CNT_W, default 12, width of on-time and period counters.
REQ-003 SHALL have port clk  input  1  clock; all logic is on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port en  input  1  measurement enable.
REQ-006 SHALL have port pwm_in  input  1  asynchronous PWM waveform being decoded.
REQ-007 SHALL have port on_time  output  CNT_W  last measured high time, in clk cycles.
REQ-008 SHALL have port period  output  CNT_W  last measured rise-to-rise period, in clk cycles.
REQ-009 SHALL have port duty_code  output  9  decoded duty, floor(on_time*512/period).
REQ-010 SHALL have port meas_valid  output  1  one-cycle pulse when all three results update.
REQ-011 SHALL have port busy  output  1  high while the divider iterates.
REQ-012 SHALL have port stuck  output  1  high when the last result came from a timeout.
REQ-013 SHALL have port err_short  output  1  one-cycle pulse when a period < MIN_PERIOD is dropped.

Function
REQ-014 SHALL pass pwm_in through a 2-FF synchronizer (pwm_s); rise = pwm_s & ~pwm_s_d; fall = ~pwm_s & pwm_s_d.
REQ-015 SHALL implement FSM states IDLE, WAIT_RISE, HIGH, LOW.
REQ-016 SHALL move from IDLE to WAIT_RISE when en=1; SHALL return to IDLE from any state within 1 cycle of en=0, clear the counters, abort the divider, and hold the result outputs.
REQ-017 SHALL, in WAIT_RISE, ignore fall edges, go to HIGH on rise, and not produce a result (partial first period is discarded).
REQ-018 SHALL count on_cnt in HIGH and off time in LOW; per_cnt SHALL count every cycle from a rise up to and including the cycle before the next rise; on_cnt SHALL count the cycles with pwm_s=1 in that span; the rise cycle SHALL count as 1 in both.
REQ-019 SHALL move HIGH->LOW on fall, and LOW->HIGH on rise.
REQ-020 SHALL, on a rise in LOW, capture on_cnt and per_cnt into on_time and period, then restart per_cnt=1 and on_cnt=1.
REQ-021 SHALL, when a captured per_cnt >= MIN_PERIOD, start a restoring divider on (on_time<<9)/period, producing 1 quotient bit per cycle over 9 cycles, with busy=1.
REQ-022 SHALL update duty_code and pulse meas_valid on the cycle after the 9th iteration, i.e. 10 cycles after the rise-detect cycle; on_time and period SHALL change on that same cycle, never earlier.
REQ-023 SHALL, when a captured per_cnt < MIN_PERIOD, drop the sample, pulse err_short, leave outputs unchanged and start no division.
REQ-024 SHALL clamp duty_code to 511 (it can only be reached via timeout, since on_time < period).
REQ-025 SHALL treat per_cnt reaching 2^CNT_W-1 as a timeout: in HIGH, output on_time=period=all-ones, duty_code=511, stuck=1; in LOW, output on_time=0, period=all-ones, duty_code=0, stuck=1; SHALL pulse meas_valid on the next cycle, and go to WAIT_RISE.
REQ-026 SHALL clear stuck on the next normal meas_valid.
REQ-027 SHALL never pulse meas_valid and err_short on the same cycle.

Reset
REQ-028 SHALL, on rst=1, asynchronously put the FSM in IDLE, clear the synchronizer and counters, and set on_time=0, period=0, duty_code=0, meas_valid=0, busy=0, stuck=0 and err_short=0.
REQ-029 SHALL discard any in-progress measurement when reset is asserted mid-operation; the first result after release requires two full rises.

Verification
REQ-030 en=1, pwm_in with period 64 and high 32, repeating -> first meas_valid after the 2nd rise: on_time=32, period=64, duty_code=256, stuck=0.
REQ-031 Period 64, high 1 -> duty_code=8; high 63 -> duty_code=504; meas_valid arrives 10 cycles after each synchronized rise.
REQ-032 Period 10 (< MIN_PERIOD) -> err_short pulses each period, meas_valid stays 0, outputs hold their previous values.
REQ-033 pwm_in held high for 5000 cycles -> meas_valid with duty_code=511, period=4095, stuck=1; then a 64/16 waveform -> duty_code=128, stuck=0.
REQ-034 en dropped while busy=1 -> busy=0 within 1 cycle, no meas_valid, outputs unchanged.
REQ-035 rst pulse mid-HIGH -> all outputs 0; after release, no meas_valid until the second full rise.

Source files
------------

// File: rtl/pwm_duty_capture.sv
// PWM duty-cycle decoder: measures rise-to-rise period and high time of an
// asynchronous PWM input and reports a 9-bit duty code via a serial divider.
module pwm_duty_capture #(
  parameter int unsigned MIN_PERIOD = 16,
  parameter int unsigned CNT_W      = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] on_time,
  output logic [CNT_W-1:0] period,
  output logic [8:0]       duty_code,
  output logic             meas_valid,
  output logic             busy,
  output logic             stuck,
  output logic             err_short
);

  localparam int unsigned DUTY_W    = 9;
  localparam int unsigned ITER_W    = 4;
  localparam int unsigned DIV_ITERS = 9;
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [DUTY_W-1:0] DUTY_MAX  = '1;
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(DIV_ITERS - 1);

  typedef enum logic [1:0] {IDLE, WAIT_RISE, HIGH, LOW} state_e;

  state_e              state_q, state_d;
  logic                sync1_q, pwm_s_q, pwm_s_d_q;
  logic                rise, fall;
  logic [CNT_W-1:0]    per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0]    on_cnt_q, on_cnt_d;
  logic                busy_q, busy_d;
  logic [ITER_W-1:0]   div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic [DUTY_W-1:0]   quo_q, quo_d;
  logic [CNT_W-1:0]    dvsr_q, dvsr_d;
  logic [CNT_W-1:0]    cap_on_q, cap_on_d;
  logic                clamp_q, clamp_d;
  logic [CNT_W-1:0]    on_time_q, on_time_d;
  logic [CNT_W-1:0]    period_q, period_d;
  logic [DUTY_W-1:0]   duty_q, duty_d;
  logic                mv_q, mv_d;
  logic                stuck_q, stuck_d;
  logic                err_q, err_d;
  logic                err_pend_q, err_pend_d;
  logic                short_ev;
  logic                err_any;
  logic [CNT_W:0]      rem_sh;
  logic                div_ge;
  logic [CNT_W-1:0]    rem_nx;
  logic [DUTY_W-1:0]   quo_nx;

  assign rise = pwm_s_q & ~pwm_s_d_q;
  assign fall = ~pwm_s_q & pwm_s_d_q;

  // One restoring-division step; remainder stays below the divisor so CNT_W bits suffice
  assign rem_sh = {rem_q, 1'b0};
  assign div_ge = rem_sh >= {1'b0, dvsr_q};
  assign rem_nx = div_ge ? CNT_W'(rem_sh - {1'b0, dvsr_q}) : rem_sh[CNT_W-1:0];
  assign quo_nx = {quo_q[DUTY_W-2:0], div_ge};

  always_comb begin
    state_d    = state_q;
    per_cnt_d  = per_cnt_q;
    on_cnt_d   = on_cnt_q;
    busy_d     = busy_q;
    div_cnt_d  = div_cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvsr_d     = dvsr_q;
    cap_on_d   = cap_on_q;
    clamp_d    = clamp_q;
    on_time_d  = on_time_q;
    period_d   = period_q;
    duty_d     = duty_q;
    mv_d       = 1'b0;
    stuck_d    = stuck_q;
    short_ev   = 1'b0;

    if (busy_q) begin
      rem_d     = rem_nx;
      quo_d     = quo_nx;
      div_cnt_d = div_cnt_q + ITER_W'(1);
      if (div_cnt_q == ITER_LAST) begin
        busy_d    = 1'b0;
        mv_d      = 1'b1;
        on_time_d = cap_on_q;
        period_d  = dvsr_q;
        duty_d    = clamp_q ? DUTY_MAX : quo_nx;
        stuck_d   = 1'b0;
      end
    end

    case (state_q)
      IDLE: begin
        if (en) state_d = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (rise) begin
          state_d   = HIGH;
          per_cnt_d = CNT_W'(1);
          on_cnt_d  = CNT_W'(1);
        end
      end
      HIGH, LOW: begin
        if (state_q == LOW && rise) begin
          state_d   = HIGH;
          per_cnt_d = CNT_W'(1);
          on_cnt_d  = CNT_W'(1);
          if (per_cnt_q < CNT_W'(MIN_PERIOD)) begin
            short_ev = 1'b1;
          end else begin
            busy_d    = 1'b1;
            div_cnt_d = '0;
            dvsr_d    = per_cnt_q;
            cap_on_d  = on_cnt_q;
            clamp_d   = on_cnt_q >= per_cnt_q;
            rem_d     = (on_cnt_q >= per_cnt_q) ? '0 : on_cnt_q;
            quo_d     = '0;
          end
        end else if (per_cnt_q == CNT_MAX) begin
          // No edge for a full counter span: report a stuck line and resync
          state_d   = WAIT_RISE;
          per_cnt_d = '0;
          on_cnt_d  = '0;
          busy_d    = 1'b0;
          mv_d      = 1'b1;
          stuck_d   = 1'b1;
          period_d  = CNT_MAX;
          on_time_d = (state_q == HIGH) ? CNT_MAX : '0;
          duty_d    = (state_q == HIGH) ? DUTY_MAX : '0;
        end else begin
          per_cnt_d = per_cnt_q + CNT_W'(1);
          on_cnt_d  = on_cnt_q + CNT_W'(pwm_s_q);
          if (state_q == HIGH && fall) state_d = LOW;
        end
      end
      default: state_d = IDLE;
    endcase

    // Disable wins over everything: abort, clear counters, keep last results
    if (!en) begin
      state_d   = IDLE;
      per_cnt_d = '0;
      on_cnt_d  = '0;
      busy_d    = 1'b0;
      mv_d      = 1'b0;
      short_ev  = 1'b0;
      on_time_d = on_time_q;
      period_d  = period_q;
      duty_d    = duty_q;
      stuck_d   = stuck_q;
    end

    // A dropped sample colliding with a result is reported one cycle later
    err_any    = short_ev | (err_pend_q & en);
    err_d      = err_any & ~mv_d;
    err_pend_d = err_any & mv_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sync1_q    <= 1'b0;
      pwm_s_q    <= 1'b0;
      pwm_s_d_q  <= 1'b0;
      per_cnt_q  <= '0;
      on_cnt_q   <= '0;
      busy_q     <= 1'b0;
      div_cnt_q  <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvsr_q     <= '0;
      cap_on_q   <= '0;
      clamp_q    <= 1'b0;
      on_time_q  <= '0;
      period_q   <= '0;
      duty_q     <= '0;
      mv_q       <= 1'b0;
      stuck_q    <= 1'b0;
      err_q      <= 1'b0;
      err_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= pwm_in;
      pwm_s_q    <= sync1_q;
      pwm_s_d_q  <= pwm_s_q;
      per_cnt_q  <= per_cnt_d;
      on_cnt_q   <= on_cnt_d;
      busy_q     <= busy_d;
      div_cnt_q  <= div_cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvsr_q     <= dvsr_d;
      cap_on_q   <= cap_on_d;
      clamp_q    <= clamp_d;
      on_time_q  <= on_time_d;
      period_q   <= period_d;
      duty_q     <= duty_d;
      mv_q       <= mv_d;
      stuck_q    <= stuck_d;
      err_q      <= err_d;
      err_pend_q <= err_pend_d;
    end
  end

  assign on_time    = on_time_q;
  assign period     = period_q;
  assign duty_code  = duty_q;
  assign meas_valid = mv_q;
  assign busy       = busy_q;
  assign stuck      = stuck_q;
  assign err_short  = err_q;

endmodule
